// File: rtl/dm_load_unit_if.sv
// -----------------------------------------------------------------------------
// dm_load_unit_if
// Read port between the MEM-stage load unit and the multi-cycle data memory.
//
//   rd_req   load unit -> memory   read request, held until rd_ack or timeout
//   rd_addr  load unit -> memory   word-aligned address, stable while rd_req=1
//   rd_ack   memory -> load unit   read data valid; rd_data sampled on same edge
//   rd_data  memory -> load unit   32-bit read word
//
// Modports: master = load unit side, slave = memory side.
// -----------------------------------------------------------------------------
interface dm_rd_if;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_ack;
    logic [31:0] rd_data;

    modport master (
        output rd_req,
        output rd_addr,
        input  rd_ack,
        input  rd_data
    );

    modport slave (
        input  rd_req,
        input  rd_addr,
        output rd_ack,
        output rd_data
    );
endinterface

// File: rtl/dm_load_unit.sv
// -----------------------------------------------------------------------------
// dm_load_unit
// MEM-stage load unit executing lw/lh/lhu/lb/lbu. A load in range issues one
// word-aligned read on the memory port and holds the pipeline (stall) until
// the word returns; the addressed byte/half is then picked out with the same
// lane mapping as the store byte enables and sign- or zero-extended.
// Out-of-range addresses and memory timeouts return 0 with bus_err set.
//
// Parameters
//   DM_WORDS_LOG2  memory depth in words (log2); hit = addr[31:DM_WORDS_LOG2+2]==0
//   TIMEOUT        REQ cycles without rd_ack before bus error; 0 = wait forever
//
// Ports
//   clk        in   clock, all state on posedge
//   reset      in   synchronous active-high reset
//   ld_valid   in   load present in MEM stage (held by pipeline while stall=1)
//   ld_type    in   000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, others lw
//   addr       in   effective byte address
//   rd_bus     --   dm_rd_if.master read port to the data memory
//   stall      out  hold pipeline (combinational)
//   load_data  out  extended result, held until the next load_done
//   load_done  out  one-cycle pulse: load_data/bus_err/adel valid
//   bus_err    out  last load was out of range or timed out
//   adel       out  misaligned-load exception
//
// Build option
//   MISALIGN_EXC_EN  when defined, misaligned lw/lh/lhu are rejected with
//                    adel=1 and no memory access; otherwise adel is tied 0 and
//                    the low address bits only steer lane selection.
// -----------------------------------------------------------------------------
module dm_load_unit #(
    parameter int unsigned DM_WORDS_LOG2 = 11,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_valid,
    input  logic [2:0]    ld_type,
    input  logic [31:0]   addr,
    dm_rd_if.master       rd_bus,
    output logic          stall,
    output logic [31:0]   load_data,
    output logic          load_done,
    output logic          bus_err,
    output logic          adel
);

    // Counter only has to reach TIMEOUT-1; keep at least one bit so the
    // TIMEOUT=0 (never) build still elaborates.
    localparam int unsigned    CNT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int unsigned    TO_LAST_I = (TIMEOUT == 0) ? 0 : (TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TO_LAST = TO_LAST_I[CNT_W-1:0];
    localparam bit             TO_EN     = (TIMEOUT != 0);
    localparam int unsigned    HIT_LSB   = DM_WORDS_LOG2 + 2;

    localparam logic [2:0] LT_LW  = 3'd0;
    localparam logic [2:0] LT_LH  = 3'd1;
    localparam logic [2:0] LT_LHU = 3'd2;
    localparam logic [2:0] LT_LB  = 3'd3;
    localparam logic [2:0] LT_LBU = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic              rd_req_r;
    logic [31:0]       rd_addr_r;
    logic [31:0]       load_data_r;
    logic              load_done_r;
    logic              bus_err_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [2:0]        type_r;
    logic [1:0]        off_r;
    logic              hit_s;
    logic              stall_s;
`ifdef MISALIGN_EXC_EN
    logic              adel_r;
    logic              misalign_s;
`endif

    // Pick the addressed lane out of the returned word and extend it.
    // Lane k of the word is rd_data[8k+7:8k], matching the store byte enables.
    function automatic logic [31:0] extract(input logic [2:0]  ltype,
                                            input logic [1:0]  off,
                                            input logic [31:0] word);
        logic [15:0] half_v;
        logic [7:0]  byte_v;
        logic [31:0] res_v;
        half_v = off[1] ? word[31:16] : word[15:0];
        case (off)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            2'd3:    byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        case (ltype)
            LT_LH:   res_v = {{16{half_v[15]}}, half_v};
            LT_LHU:  res_v = {16'h0000, half_v};
            LT_LB:   res_v = {{24{byte_v[7]}}, byte_v};
            LT_LBU:  res_v = {24'h000000, byte_v};
            default: res_v = word;   // lw and the unused 101-111 codes
        endcase
        return res_v;
    endfunction

`ifdef MISALIGN_EXC_EN
    // Word loads need addr[1:0]==0, half loads need addr[0]==0.
    function automatic logic is_misaligned(input logic [2:0] ltype,
                                           input logic [1:0] off);
        logic mis_v;
        case (ltype)
            LT_LH, LT_LHU: mis_v = off[0];
            LT_LB, LT_LBU: mis_v = 1'b0;
            default:       mis_v = (off != 2'b00);
        endcase
        return mis_v;
    endfunction

    // Alignment check of the load currently presented in IDLE.
    always_comb begin
        misalign_s = is_misaligned(ld_type, addr[1:0]);
    end
`endif

    // Address range decode: everything above the memory depth must be zero.
    always_comb begin
        hit_s = ((addr >> HIT_LSB) == 32'd0);
    end

    // Pipeline hold: accepting in IDLE or waiting in REQ; never during reset
    // and never in DONE, so the pipeline advances on the DONE edge.
    always_comb begin
        stall_s = 1'b0;
        if (reset) begin
            stall_s = 1'b0;
        end else begin
            stall_s = ((state_r == ST_IDLE) && ld_valid) || (state_r == ST_REQ);
        end
    end

    // Load FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            rd_req_r    <= 1'b0;
            rd_addr_r   <= 32'h0000_0000;
            load_data_r <= 32'h0000_0000;
            load_done_r <= 1'b0;
            bus_err_r   <= 1'b0;
            cnt_r       <= '0;
            type_r      <= 3'd0;
            off_r       <= 2'd0;
`ifdef MISALIGN_EXC_EN
            adel_r      <= 1'b0;
`endif
        end else begin
            load_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (ld_valid) begin
`ifdef MISALIGN_EXC_EN
                        // Every accepted load rewrites adel, so it clears here.
                        adel_r <= misalign_s;
                        if (misalign_s) begin
                            load_data_r <= 32'h0000_0000;
                            bus_err_r   <= 1'b0;
                            load_done_r <= 1'b1;
                            state_r     <= ST_DONE;
                        end else if (!hit_s) begin
`else
                        if (!hit_s) begin
`endif
                            // Out of range: fail without touching the bus.
                            load_data_r <= 32'h0000_0000;
                            bus_err_r   <= 1'b1;
                            load_done_r <= 1'b1;
                            state_r     <= ST_DONE;
                        end else begin
                            rd_req_r  <= 1'b1;
                            rd_addr_r <= {addr[31:2], 2'b00};
                            type_r    <= ld_type;
                            off_r     <= addr[1:0];
                            cnt_r     <= '0;
                            state_r   <= ST_REQ;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    // An ack on the last allowed cycle still wins over timeout.
                    if (rd_bus.rd_ack) begin
                        rd_req_r    <= 1'b0;
                        load_data_r <= extract(type_r, off_r, rd_bus.rd_data);
                        bus_err_r   <= 1'b0;
                        load_done_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end else if (TO_EN && (cnt_r == TO_LAST)) begin
                        rd_req_r    <= 1'b0;
                        load_data_r <= 32'h0000_0000;
                        bus_err_r   <= 1'b1;
                        load_done_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1'b1);
                    end
                end
                ST_DONE: begin
                    // ld_valid is ignored here so the retiring load is not re-accepted.
                    state_r <= ST_IDLE;
                end
                default: begin
                    rd_req_r <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_bus.rd_req  = rd_req_r;
    assign rd_bus.rd_addr = rd_addr_r;
    assign stall          = stall_s;
    assign load_data      = load_data_r;
    assign load_done      = load_done_r;
    assign bus_err        = bus_err_r;
`ifdef MISALIGN_EXC_EN
    assign adel           = adel_r;
`else
    assign adel           = 1'b0;
`endif

endmodule

// File: tb/tb_dm_load_unit.sv
// -----------------------------------------------------------------------------
// tb_dm_load_unit
// Directed and randomized loads against dm_load_unit (TIMEOUT=4). Inputs are
// driven 1 time unit after posedge, outputs sampled at negedge. Expected
// results come from an arithmetic model of the load rules.
// -----------------------------------------------------------------------------
module tb_dm_load_unit;

    localparam int TO = 4;
`ifdef MISALIGN_EXC_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_valid;
    logic [2:0]  ld_type;
    logic [31:0] addr;
    logic        stall;
    logic [31:0] load_data;
    logic        load_done;
    logic        bus_err;
    logic        adel;

    int total = 0;
    int bad   = 0;

    dm_rd_if bus ();

    dm_load_unit #(
        .DM_WORDS_LOG2 (11),
        .TIMEOUT       (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ld_valid  (ld_valid),
        .ld_type   (ld_type),
        .addr      (addr),
        .rd_bus    (bus),
        .stall     (stall),
        .load_data (load_data),
        .load_done (load_done),
        .bus_err   (bus_err),
        .adel      (adel)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Load result from the lane rules, using plain integer arithmetic.
    function automatic logic [31:0] ref_extract(input logic [2:0] t, input logic [31:0] a,
                                                input logic [31:0] d);
        int unsigned k, v;
        k = a % 4;
        case (t)
            3'd1, 3'd2: begin
                v = (d >> (16 * (k / 2))) % 65536;
                if (t == 3'd1 && v >= 32768) v = v - 65536;
            end
            3'd3, 3'd4: begin
                v = (d >> (8 * k)) % 256;
                if (t == 3'd3 && v >= 128) v = v - 256;
            end
            default: v = d;
        endcase
        return v;
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] t, input logic [31:0] a);
        if (t == 3'd1 || t == 3'd2) return (a % 2) != 0;
        if (t == 3'd3 || t == 3'd4) return 1'b0;
        return (a % 4) != 0;
    endfunction

    // One complete load. dly = REQ cycle (0-based) carrying rd_ack; dly>=TO never acks.
    task automatic do_load(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                           input int dly);
        bit          hit, mis, acked, exp_be, exp_ad;
        logic [31:0] exp_ld;
        hit    = (a / 32'h2000) == 0;
        mis    = MIS_EN && ref_misaligned(t, a);
        acked  = 1'b0;
        exp_ad = 1'b0;
        drive_edge();
        ld_valid    = 1'b1;
        ld_type     = t;
        addr        = a;
        bus.rd_ack  = 1'b0;
        bus.rd_data = $urandom;
        sample();
        chk("accept_stall", stall, 1);
        chk("accept_req", bus.rd_req, 0);
        chk("accept_done", load_done, 0);
        if (mis) begin
            exp_ld = 0; exp_be = 0; exp_ad = 1;
        end else if (!hit) begin
            exp_ld = 0; exp_be = 1;
        end else begin
            for (int n = 0; n < TO && !acked; n++) begin
                drive_edge();
                addr        = $urandom;                 // latched copies must be used
                ld_type     = 3'($urandom_range(7, 0));
                acked       = (n == dly);
                bus.rd_ack  = acked;
                bus.rd_data = acked ? d : $urandom;
                sample();
                chk("req_high", bus.rd_req, 1);
                chk("req_addr", bus.rd_addr, {a[31:2], 2'b00});
                chk("req_stall", stall, 1);
                chk("req_no_done", load_done, 0);
            end
            if (acked) begin
                exp_ld = ref_extract(t, a, d); exp_be = 0;
            end else begin
                exp_ld = 0; exp_be = 1;
            end
        end
        drive_edge();
        bus.rd_ack = 1'b0;
        addr       = a;
        ld_type    = t;
        sample();
        chk("done_pulse", load_done, 1);
        chk("done_data", load_data, exp_ld);
        chk("done_err", bus_err, exp_be);
        chk("done_adel", adel, exp_ad);
        chk("done_req", bus.rd_req, 0);
        chk("done_stall", stall, 0);
        drive_edge();
        ld_valid = 1'b0;
        addr     = $urandom;
        sample();
        chk("after_done", load_done, 0);
        chk("hold_data", load_data, exp_ld);
        chk("hold_err", bus_err, exp_be);
        chk("idle_stall", stall, 0);
    endtask

    initial begin
        logic [2:0]  rt;
        logic [31:0] ra;
        reset       = 1'b1;
        ld_valid    = 1'b1;
        ld_type     = 3'd0;
        addr        = 32'h10;
        bus.rd_ack  = 1'b0;
        bus.rd_data = 32'h0;

        // Reset state; stall forced low even with a load presented.
        repeat (2) drive_edge();
        sample();
        chk("rst_req", bus.rd_req, 0);
        chk("rst_addr", bus.rd_addr, 0);
        chk("rst_data", load_data, 0);
        chk("rst_done", load_done, 0);
        chk("rst_err", bus_err, 0);
        chk("rst_adel", adel, 0);
        chk("rst_stall", stall, 0);
        drive_edge();
        reset    = 1'b0;
        ld_valid = 1'b0;
        sample();
        chk("idle_stall0", stall, 0);

        // lw with ack on third REQ cycle: stall high 4 cycles.
        do_load(3'd0, 32'h10, 32'hDEADBEEF, 2);
        chk("t1_lw", load_data, 32'hDEADBEEF);

        // Lane extraction.
        do_load(3'd3, 32'h13, 32'h80112233, 0);
        chk("t2_lb", load_data, 32'hFFFFFF80);
        do_load(3'd4, 32'h13, 32'h80112233, 1);
        chk("t2_lbu", load_data, 32'h00000080);
        do_load(3'd1, 32'h12, 32'h80112233, 0);
        chk("t2_lh", load_data, 32'hFFFF8011);
        do_load(3'd2, 32'h10, 32'h80112233, 3);
        chk("t2_lhu", load_data, 32'h00002233);

        // Out of range.
        do_load(3'd0, 32'h00004000, 32'h12345678, 0);
        chk("t3_miss_data", load_data, 0);
        chk("t3_miss_err", bus_err, 1);

        // Timeout, then a stray ack must change nothing.
        do_load(3'd0, 32'h20, 32'h55AA55AA, TO);
        chk("t4_to_err", bus_err, 1);
        drive_edge();
        bus.rd_ack  = 1'b1;
        bus.rd_data = 32'hCAFEF00D;
        sample();
        chk("t4_stray_done", load_done, 0);
        chk("t4_stray_req", bus.rd_req, 0);
        drive_edge();
        bus.rd_ack = 1'b0;
        sample();
        chk("t4_stray_data", load_data, 0);
        chk("t4_stray_err", bus_err, 1);

        // Reset in REQ aborts the load; late ack ignored.
        drive_edge();
        ld_valid = 1'b1;
        ld_type  = 3'd0;
        addr     = 32'h40;
        sample();
        drive_edge();
        sample();
        chk("t5_req_up", bus.rd_req, 1);
        drive_edge();
        reset = 1'b1;
        sample();
        chk("t5_rst_stall", stall, 0);
        drive_edge();
        reset       = 1'b0;
        ld_valid    = 1'b0;
        bus.rd_ack  = 1'b1;
        bus.rd_data = 32'h11111111;
        sample();
        chk("t5_req_drop", bus.rd_req, 0);
        chk("t5_no_done", load_done, 0);
        drive_edge();
        bus.rd_ack = 1'b0;
        sample();
        chk("t5_no_done2", load_done, 0);
        chk("t5_data_clr", load_data, 0);
        do_load(3'd0, 32'h4, 32'h0BADC0DE, 1);
        chk("t5_lw_after", load_data, 32'h0BADC0DE);

        // Misaligned word load.
        do_load(3'd0, 32'h2, 32'hA5A5F00F, 0);
        chk("t6_data", load_data, MIS_EN ? 32'h0 : 32'hA5A5F00F);
        chk("t6_adel", adel, MIS_EN ? 32'h1 : 32'h0);

        // Randomized mix of types, hits/misses and ack delays.
        for (int i = 0; i < 60; i++) begin
            rt = 3'($urandom_range(7, 0));
            if ($urandom_range(7, 0) == 0) begin
                ra = $urandom;
                if (ra < 32'h2000) ra = ra | 32'h8000_0000;
            end else begin
                ra = $urandom & 32'h1FFF;
            end
            do_load(rt, ra, $urandom, $urandom_range(TO, 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
